// File: rtl/seq_shift_add_mult.sv
// Purpose : iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.
// Latency : C edges from acceptance to out_valid (C = WIDTH, or 1..WIDTH with early exit), +1 edge when the result is negative.
// Backpr. : single operation in flight; in_ready only in IDLE, product held with out_valid until out_ready.
//
// Ports:
//   clk, reset           - rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  - operand handshake (a, b, signed_op sampled on acceptance)
//   a, b                 - multiplicand / multiplier, WIDTH bits
//   signed_op            - 1 = two's-complement operands and product
//   busy                 - high while iterating or negating
//   out_valid / out_ready- result handshake; product stable while out_valid is high
//   product              - registered 2*WIDTH-bit result

module seq_shift_add_mult #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_op,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  // Counter must hold the value WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_NEG  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  // ------------------------------------------------------------------
  // Operand magnitudes. Negating -2^(WIDTH-1) wraps back to the same bit
  // pattern, which read as unsigned is exactly 2^(WIDTH-1).
  // ------------------------------------------------------------------
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             neg_in;

  always_comb begin
    a_mag  = (signed_op && a[WIDTH-1]) ? -a : a;
    b_mag  = (signed_op && b[WIDTH-1]) ? -b : b;
    neg_in = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
  end

  // ------------------------------------------------------------------
  // One iteration of the datapath. The accumulator low half starts as the
  // multiplier; after k shifts its low WIDTH-k bits are the multiplier bits
  // not yet consumed, and its upper k bits are finished product bits.
  // ------------------------------------------------------------------
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   shifted;
  logic [2*WIDTH-1:0]   acc_exit;
  logic [CW-1:0]        cnt_inc;
  logic [CW-1:0]        rem_cnt;
  logic [WIDTH-1:0]     rem_mask;
  logic                 rem_zero;
  logic                 calc_last;

  always_comb begin
    // Add with an explicit carry bit so the high half cannot overflow.
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    shifted  = {sum, acc_q[WIDTH-1:1]};
    cnt_inc  = cnt_q + CW'(1);

    // Mask selecting the multiplier bits still waiting to be consumed.
    rem_mask = {WIDTH{1'b1}} >> cnt_inc;
    rem_zero = ((shifted[WIDTH-1:0] & rem_mask) == '0);
    rem_cnt  = CW'(WIDTH) - cnt_inc;

    calc_last = (cnt_inc == CW'(WIDTH)) || ((EARLY_EXIT != 0) && rem_zero);

    // Skipped iterations would only add zero and shift, so one bulk shift
    // by the remaining count lands on the same alignment as a full run.
    // On a normal (counter) exit rem_cnt is zero and this is a no-op.
    acc_exit = shifted >> rem_cnt;
  end

  // ------------------------------------------------------------------
  // Next-state and register updates.
  // ------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d = a_mag;
          neg_d   = neg_in;
          acc_d   = {{WIDTH{1'b0}}, b_mag};
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        cnt_d = cnt_inc;
        if (calc_last) begin
          acc_d = acc_exit;
          if (neg_q) begin
            state_d = S_NEG;
          end else begin
            product_d = acc_exit;
            state_d   = S_DONE;
          end
        end else begin
          acc_d = shifted;
        end
      end

      S_NEG: begin
        // Magnitude product never exceeds 2^(2*WIDTH-2), so negation is exact.
        product_d = -acc_q;
        state_d   = S_DONE;
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  // Outputs decode only registered state.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q == S_CALC) || (state_q == S_NEG);
    out_valid = (state_q == S_DONE);
    product   = product_q;
  end

endmodule
